// File: rtl/seven_segment_scanner.sv
// Time-multiplexed driver for a four-digit, common-anode seven-segment display.
// Each digit is lit for REFRESH_CYCLES clocks; a frame's content is latched once per frame.
module seven_segment_scanner #(
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] display_in [3:0],
  input  logic [3:0] blank_in,
  input  logic [3:0] dp_in,
  input  logic       enable,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(REFRESH_CYCLES - 1);

  logic [CNT_W-1:0] cnt_p0;
  logic [1:0]       idx_p0;
  logic [3:0]       digit_p0 [3:0];
  logic [3:0]       blank_p0;
  logic [3:0]       dpsel_p0;
  logic             term_p0;

  // Active-low cathode pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    unique case (nib)
      4'h0: pat = 7'b1000000;
      4'h1: pat = 7'b1111001;
      4'h2: pat = 7'b0100100;
      4'h3: pat = 7'b0110000;
      4'h4: pat = 7'b0011001;
      4'h5: pat = 7'b0010010;
      4'h6: pat = 7'b0000010;
      4'h7: pat = 7'b1111000;
      4'h8: pat = 7'b0000000;
      4'h9: pat = 7'b0010000;
      4'hA: pat = 7'b0001000;
      4'hB: pat = 7'b0000011;
      4'hC: pat = 7'b1000110;
      4'hD: pat = 7'b0100001;
      4'hE: pat = 7'b0000110;
      default: pat = 7'b0001110;
    endcase
    return pat;
  endfunction

  function automatic logic [3:0] anode_select(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  assign term_p0 = (cnt_p0 == TERM);

  // Stage p0: prescaler, digit index and per-frame snapshot.
  // The snapshot starts fully blanked so nothing lights before real data is latched.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p0     <= '0;
      idx_p0     <= '0;
      blank_p0   <= 4'hF;
      dpsel_p0   <= 4'h0;
      frame_done <= 1'b0;
      for (int i = 0; i < 4; i++) digit_p0[i] <= 4'h0;
    end else begin
      frame_done <= 1'b0;
      if (enable) begin
        if (term_p0) begin
          cnt_p0 <= '0;
          idx_p0 <= idx_p0 + 2'd1;
          if (idx_p0 == 2'd3) begin
            for (int i = 0; i < 4; i++) digit_p0[i] <= display_in[i];
            blank_p0   <= blank_in;
            dpsel_p0   <= dp_in;
            frame_done <= 1'b1;
          end
        end else begin
          cnt_p0 <= cnt_p0 + 1'b1;
        end
      end
    end
  end

  // Stage p1: registered pin drivers, one cycle behind the scan state.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 4'hF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else if (!enable || blank_p0[idx_p0]) begin
      an  <= 4'hF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= anode_select(idx_p0);
      seg <= hex_decode(digit_p0[idx_p0]);
      dp  <= ~dpsel_p0[idx_p0];
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner with a cycle-count reference model
// of the scan schedule (REFRESH_CYCLES = 4).
module tb_seven_segment_scanner;

  localparam int R     = 4;
  localparam int FRAME = 4 * R;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] display_in [3:0];
  logic [3:0] blank_in;
  logic [3:0] dp_in;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  seven_segment_scanner #(.REFRESH_CYCLES(R)) dut (
    .clk        (clk),
    .reset      (reset),
    .display_in (display_in),
    .blank_in   (blank_in),
    .dp_in      (dp_in),
    .enable     (enable),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } out_t;

  out_t exp_q [$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   done       = 0;

  // Reference model: enabled cycles elapsed within the frame, plus latched frame content.
  int         a;
  int         m_dig [4];
  logic [3:0] m_blank;
  logic [3:0] m_dp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    out_t e;
    int   i;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    e.fd  = 1'b0;
    if (reset) begin
      a = 0;
      for (int k = 0; k < 4; k++) m_dig[k] = 0;
      m_blank = 4'hF;
      m_dp    = 4'h0;
    end else if (enable) begin
      i = (a / R) % 4;
      if (!m_blank[i]) begin
        e.an[i] = 1'b0;
        e.seg   = SEG_TAB[m_dig[i]];
        e.dp    = ~m_dp[i];
      end
      if (a == FRAME - 1) begin
        e.fd = 1'b1;
        for (int k = 0; k < 4; k++) m_dig[k] = int'(display_in[k]);
        m_blank = blank_in;
        m_dp    = dp_in;
      end
      a = (a + 1) % FRAME;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (a != target && guard < 200) begin
      step();
      guard++;
    end
    if (a != target) begin
      compared++;
      mismatched++;
      $display("FAIL run_to: model position %0d, required %0d", a, target);
    end
  endtask

  task automatic set_display(input logic [3:0] d3, input logic [3:0] d2,
                             input logic [3:0] d1, input logic [3:0] d0);
    display_in[3] = d3;
    display_in[2] = d2;
    display_in[1] = d1;
    display_in[0] = d0;
  endtask

  // Monitor: one DUT output sample per cycle, matched to the oldest expectation.
  initial begin
    out_t e;
    out_t got;
    @(posedge clk);
    while (!done) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e       = exp_q.pop_front();
        got.an  = an;
        got.seg = seg;
        got.dp  = dp;
        got.fd  = frame_done;
        compared++;
        if (got !== e || $countones(~an) > 1) begin
          mismatched++;
          $display("FAIL out t=%0t: got an=%b seg=%b dp=%b fd=%b, required an=%b seg=%b dp=%b fd=%b",
                   $time, got.an, got.seg, got.dp, got.fd, e.an, e.seg, e.dp, e.fd);
        end
      end
    end
  end

  initial begin
    #2000000;
    mismatched++;
    $display("FAIL watchdog: time limit reached, %0d expectations pending", exp_q.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    blank_in = 4'h0;
    dp_in    = 4'h0;
    set_display(4'h4, 4'h3, 4'h2, 4'h1);
    run(3);
    reset = 1'b0;

    // Power-up: dark frame, then 1,2,3,4 on digits 0..3.
    run(2 * FRAME + 4);

    // New content latched only at the next frame boundary.
    set_display(4'hF, 4'hA, 4'h8, 4'h0);
    run_to(0);
    run(FRAME + 2);

    // Mid-frame change while digit 1 is lit.
    run_to(R + 1);
    set_display(4'h9, 4'h5, 4'hC, 4'h7);
    run_to(0);
    run(FRAME + 1);

    // Blank digits 0 and 2, decimal point on digit 1.
    blank_in = 4'b0101;
    dp_in    = 4'b0010;
    run_to(0);
    run(FRAME + 1);

    // Enable dropped for 10 cycles inside the digit-2 slot.
    blank_in = 4'b0000;
    run_to(2 * R + 2);
    enable = 1'b0;
    run(10);
    enable = 1'b1;
    run(FRAME + R);

    // Reset coinciding with the frame-boundary terminal count.
    run_to(FRAME - 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(2 * FRAME + 2);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0)
        set_display(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 29) == 0) blank_in = 4'($urandom);
      if ($urandom_range(0, 29) == 0) dp_in    = 4'($urandom);
      enable = ($urandom_range(0, 9) != 0);
      reset  = ($urandom_range(0, 399) == 0);
      step();
    end
    reset  = 1'b0;
    enable = 1'b1;
    run(4);

    @(negedge clk);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
